// File: rtl/hart_biu_pkg.sv
// Shared configuration, types and helpers for the hart bus interface unit.
package hart_biu_pkg;

   localparam int SBUS_W_CFG     = 64;
   localparam int IMEM_LINE_CFG  = 256;
   localparam int DMEM_LINE_CFG  = 256;
   localparam int IMEM_BEATS_CFG = IMEM_LINE_CFG / SBUS_W_CFG;
   localparam int DMEM_BEATS_CFG = DMEM_LINE_CFG / SBUS_W_CFG;

   // Which cache port owns the transfer currently on the system bus.
   typedef enum logic {
      SRC_I = 1'b0,
      SRC_D = 1'b1
   } src_e;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/bus_line_buf.sv
// Line-wide staging register: beat-indexed insert for read beats, beat-indexed
// extract for write beats.
module bus_line_buf
   import hart_biu_pkg::*;
#(
   parameter int LINE = IMEM_LINE_CFG,
   parameter int W    = SBUS_W_CFG,
   parameter int BW   = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            load,
   input  logic [LINE-1:0] load_line,
   input  logic            ins_en,
   input  logic [BW-1:0]   beat,
   input  logic [W-1:0]    ins_data,
   output logic [LINE-1:0] line_next,
   output logic [W-1:0]    ext_data
);

   logic [LINE-1:0] line_q;

   // NOTE: assign a default before any conditional write in always_comb so no latch is inferred.
   always_comb begin
      line_next = line_q;
      if (ins_en) line_next[int'(beat)*W +: W] = ins_data;
   end

   assign ext_data = line_q[int'(beat)*W +: W];

   // NOTE: this wide buffer is reset on purpose: a cleared line after reset is part of the contract.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      line_q <= '0;
      else if (load)   line_q <= load_line;
      else if (ins_en) line_q <= line_next;
   end

endmodule

// File: rtl/hart_biu.sv
// Bus interface unit: arbitrates L1i refills and L1d line reads/writes onto one
// beat-based system bus, serialising and reassembling whole cache lines.
module hart_biu
   import hart_biu_pkg::*;
#(
   parameter int IMEM_LINE = IMEM_LINE_CFG,
   parameter int DMEM_LINE = DMEM_LINE_CFG,
   parameter int SBUS_W    = SBUS_W_CFG
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [63:0]          b_addr_i,
   input  logic                 b_rd_i,
   output logic [IMEM_LINE-1:0] b_data_i,
   output logic                 b_dv_i,
   input  logic [63:0]          b_addr,
   input  logic                 b_rd,
   input  logic                 b_wr,
   input  logic [DMEM_LINE-1:0] b_data_out,
   output logic [DMEM_LINE-1:0] b_data_in,
   output logic                 b_dv,
   output logic [63:0]          s_addr,
   output logic                 s_rd,
   output logic                 s_wr,
   output logic [SBUS_W-1:0]    s_wdata,
   input  logic [SBUS_W-1:0]    s_rdata,
   input  logic                 s_ack
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_XFER = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;
   localparam logic [1:0] ST_TURN = 2'd3;

   localparam int MAX_LINE  = max_int(IMEM_LINE, DMEM_LINE);
   localparam int I_BEATS   = IMEM_LINE / SBUS_W;
   localparam int D_BEATS   = DMEM_LINE / SBUS_W;
   localparam int MAX_BEATS = MAX_LINE / SBUS_W;
   localparam int BW        = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
   localparam int BEAT_SH   = $clog2(SBUS_W / 8);

   localparam logic [63:0] I_OFS_MASK = (64'd1 << $clog2(IMEM_LINE / 8)) - 64'd1;
   localparam logic [63:0] D_OFS_MASK = (64'd1 << $clog2(DMEM_LINE / 8)) - 64'd1;

   logic [1:0]          state;
   logic [BW-1:0]       beat;
   logic                last_d;
   src_e                src;
   logic                op_wr;
   logic [63:0]         base;

   logic                d_req;
   logic                grant_d;
   logic                grant_i;
   logic [BW-1:0]       last_idx;
   logic                beat_done;
   logic                line_done;
   logic                buf_load;
   logic                buf_ins;
   logic [MAX_LINE-1:0] line_next;

   // D wins unless it also won last time and I is waiting.
   assign d_req   = b_rd | b_wr;
   assign grant_d = (state == ST_IDLE) && d_req && !(last_d && b_rd_i);
   assign grant_i = (state == ST_IDLE) && b_rd_i && !grant_d;

   assign last_idx  = (src == SRC_D) ? BW'(D_BEATS - 1) : BW'(I_BEATS - 1);
   assign beat_done = (state == ST_XFER) && s_ack;
   assign line_done = beat_done && (beat == last_idx);

   // Strobes and dv decode straight from state so an async reset drops them at once.
   assign s_rd   = (state == ST_XFER) && !op_wr;
   assign s_wr   = (state == ST_XFER) && op_wr;
   assign s_addr = base | (64'(beat) << BEAT_SH);
   assign b_dv   = (state == ST_RESP) && (src == SRC_D);
   assign b_dv_i = (state == ST_RESP) && (src == SRC_I);

   // Write data is captured at grant so the requester may change it afterwards.
   assign buf_load = grant_d && b_wr;
   assign buf_ins  = beat_done && !op_wr;

   bus_line_buf #(
      .LINE (MAX_LINE),
      .W    (SBUS_W),
      .BW   (BW)
   ) u_line_buf (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (buf_load),
      .load_line (MAX_LINE'(b_data_out)),
      .ins_en    (buf_ins),
      .beat      (beat),
      .ins_data  (s_rdata),
      .line_next (line_next),
      .ext_data  (s_wdata)
   );

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= ST_IDLE;
         beat   <= '0;
         last_d <= 1'b0;
         src    <= SRC_I;
         op_wr  <= 1'b0;
         base   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               beat <= '0;
               if (grant_d) begin
                  state  <= ST_XFER;
                  src    <= SRC_D;
                  op_wr  <= b_wr;
                  base   <= b_addr & ~D_OFS_MASK;
                  last_d <= 1'b1;
               end else if (grant_i) begin
                  state  <= ST_XFER;
                  src    <= SRC_I;
                  op_wr  <= 1'b0;
                  base   <= b_addr_i & ~I_OFS_MASK;
                  last_d <= 1'b0;
               end
            end
            ST_XFER: begin
               if (s_ack) begin
                  if (line_done) begin
                     beat  <= '0;
                     state <= ST_RESP;
                  end else begin
                     beat <= beat + BW'(1);
                  end
               end
            end
            ST_RESP: state <= ST_TURN;
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Each port keeps its last completed line until its own next read finishes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         b_data_i  <= '0;
         b_data_in <= '0;
      end else if (line_done && !op_wr) begin
         if (src == SRC_D) b_data_in <= line_next[DMEM_LINE-1:0];
         else              b_data_i  <= line_next[IMEM_LINE-1:0];
      end
   end

endmodule

// File: tb/tb_hart_biu.sv
// Scoreboard bench for hart_biu: a line-level memory model predicts every bus beat
// and every completion; a monitor compares them as the DUT presents them.
module tb_hart_biu;
   import hart_biu_pkg::*;

   localparam int TIMEOUT = 300;

   logic         clk;
   logic         rst_n;
   logic [63:0]  b_addr_i, b_addr, s_addr, s_wdata, s_rdata;
   logic         b_rd_i, b_dv_i, b_rd, b_wr, b_dv, s_rd, s_wr, s_ack;
   logic [255:0] b_data_i, b_data_out, b_data_in;

   hart_biu u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .b_addr_i   (b_addr_i),
      .b_rd_i     (b_rd_i),
      .b_data_i   (b_data_i),
      .b_dv_i     (b_dv_i),
      .b_addr     (b_addr),
      .b_rd       (b_rd),
      .b_wr       (b_wr),
      .b_data_out (b_data_out),
      .b_data_in  (b_data_in),
      .b_dv       (b_dv),
      .s_addr     (s_addr),
      .s_rd       (s_rd),
      .s_wr       (s_wr),
      .s_wdata    (s_wdata),
      .s_rdata    (s_rdata),
      .s_ack      (s_ack)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct packed {
      logic        wr;
      logic [63:0] addr;
      logic [63:0] data;
   } beat_t;

   typedef struct packed {
      logic         is_d;
      logic         is_wr;
      logic [255:0] line;
   } done_t;

   beat_t        exp_beats[$];
   done_t        exp_done[$];
   logic [63:0]  model_mem [longint unsigned];
   logic [63:0]  slave_mem [longint unsigned];
   logic         model_last_d;
   logic [255:0] exp_last_i, exp_last_d;
   int           beats_since_done;
   int           n_checks, n_pass;
   logic         ack_random;
   int           stall_cnt;
   logic [63:0]  stall_addr;

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   function automatic logic [63:0] init_word(input logic [63:0] a);
      return {a[31:0] ^ 32'hc3a5_0f1e, ~a[31:0]};
   endfunction

   function automatic logic [63:0] model_rd(input logic [63:0] a);
      return model_mem.exists(a) ? model_mem[a] : init_word(a);
   endfunction

   function automatic logic [63:0] slave_rd(input logic [63:0] a);
      return slave_mem.exists(a) ? slave_mem[a] : init_word(a);
   endfunction

   function automatic logic [255:0] rand_line();
      logic [255:0] r;
      for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom();
      return r;
   endfunction

   // One whole-line transaction against the model memory image.
   task automatic model_line(input logic is_d, input logic wr, input logic [63:0] addr,
                             input logic [255:0] wline);
      logic [63:0]  base, a, d;
      logic [255:0] line;
      base = {addr[63:5], 5'b0};
      line = '0;
      for (int b = 0; b < 4; b++) begin
         a = base + 64'(8 * b);
         if (wr) begin
            d = wline[64*b +: 64];
            model_mem[a] = d;
         end else begin
            d = model_rd(a);
            line[64*b +: 64] = d;
         end
         exp_beats.push_back('{wr: wr, addr: a, data: d});
      end
      exp_done.push_back('{is_d: is_d, is_wr: wr, line: line});
      model_last_d = is_d;
   endtask

   // Service order for requests raised together and held until served.
   task automatic model_round(input logic want_i, input logic want_dr, input logic want_dw,
                              input logic [63:0] ia, input logic [63:0] da, input logic [255:0] dl);
      while (want_i || want_dr || want_dw) begin
         if ((want_dr || want_dw) && !(model_last_d && want_i)) begin
            if (want_dw) begin
               model_line(1'b1, 1'b1, da, dl);
               want_dw = 1'b0;
            end else begin
               model_line(1'b1, 1'b0, da, '0);
               want_dr = 1'b0;
            end
         end else begin
            model_line(1'b0, 1'b0, ia, '0);
            want_i = 1'b0;
         end
      end
   endtask

   task automatic wait_dv_i(output int n);
      n = 0;
      while (n < TIMEOUT) begin
         @(negedge clk);
         if (b_dv_i) break;
         n++;
      end
      if (n == TIMEOUT) check("dv_i_timeout", b_dv_i, 1'b1);
   endtask

   task automatic wait_dv_d(output int n);
      n = 0;
      while (n < TIMEOUT) begin
         @(negedge clk);
         if (b_dv) break;
         n++;
      end
      if (n == TIMEOUT) check("dv_d_timeout", b_dv, 1'b1);
   endtask

   task automatic req_i(input logic [63:0] a, input int extra_hold, output int lat);
      b_addr_i = a;
      b_rd_i   = 1'b1;
      wait_dv_i(lat);
      repeat (1 + extra_hold) @(posedge clk);
      #1 b_rd_i = 1'b0;
   endtask

   task automatic req_d(input logic rd, input logic wr, input logic [63:0] a,
                        input logic [255:0] line, output int lat);
      int n;
      b_addr     = a;
      b_data_out = line;
      b_rd       = rd;
      b_wr       = wr;
      wait_dv_d(n);
      lat = n;
      @(posedge clk);
      #1;
      if (wr) begin
         b_wr       = 1'b0;
         b_data_out = rand_line();
         if (rd) begin
            wait_dv_d(n);
            @(posedge clk);
            #1;
         end
      end
      b_rd = 1'b0;
   endtask

   // System bus slave: ack decided shortly after each edge, writes land on ack.
   initial begin
      s_ack   = 1'b0;
      s_rdata = '0;
      forever begin
         @(posedge clk);
         #2;
         if (stall_cnt > 0 && (s_rd || s_wr) && s_addr == stall_addr) begin
            s_ack = 1'b0;
            stall_cnt--;
         end else if (ack_random) begin
            s_ack = ($urandom_range(0, 3) != 0);
         end else begin
            s_ack = 1'b1;
         end
         s_rdata = slave_rd(s_addr);
         if (s_ack && s_wr) slave_mem[s_addr] = s_wdata;
      end
   end

   // Monitor: pops expected beats / completions as the DUT presents them.
   initial begin
      beat_t       eb;
      done_t       ed;
      logic        prev_stall;
      logic [63:0] prev_addr, prev_wdata;
      logic [1:0]  prev_strb;
      prev_stall = 1'b0;
      prev_addr  = '0;
      prev_wdata = '0;
      prev_strb  = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev_stall = 1'b0;
         end else begin
            if (s_rd || s_wr) check("rd_wr_exclusive", s_rd & s_wr, 1'b0);
            if (prev_stall) begin
               check("hold_strobes", {s_rd, s_wr}, prev_strb);
               check("hold_addr", s_addr, prev_addr);
               if (prev_strb[0]) check("hold_wdata", s_wdata, prev_wdata);
            end
            if ((s_rd || s_wr) && s_ack) begin
               if (exp_beats.size() == 0) begin
                  check("unexpected_beat", exp_beats.size(), 1);
               end else begin
                  eb = exp_beats.pop_front();
                  check("beat_is_write", s_wr, eb.wr);
                  check("beat_addr", s_addr, eb.addr);
                  if (eb.wr) check("beat_wdata", s_wdata, eb.data);
                  beats_since_done++;
               end
            end
            prev_stall = (s_rd || s_wr) && !s_ack;
            prev_strb  = {s_rd, s_wr};
            prev_addr  = s_addr;
            prev_wdata = s_wdata;
            if (b_dv || b_dv_i) begin
               check("dv_exclusive", b_dv & b_dv_i, 1'b0);
               check("beats_per_line", beats_since_done, 4);
               beats_since_done = 0;
               if (exp_done.size() == 0) begin
                  check("unexpected_dv", exp_done.size(), 1);
               end else begin
                  ed = exp_done.pop_front();
                  check("dv_port_is_d", b_dv, ed.is_d);
                  if (ed.is_d && !ed.is_wr) exp_last_d = ed.line;
                  if (!ed.is_d) exp_last_i = ed.line;
                  check("b_data_in", b_data_in, exp_last_d);
                  check("b_data_i", b_data_i, exp_last_i);
               end
            end
         end
      end
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: run did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int           lat, lat2, k;
      logic         found, wi, wdr, wdw;
      logic [63:0]  ia, da;
      logic [255:0] dl;

      n_checks = 0;
      n_pass = 0;
      beats_since_done = 0;
      exp_last_i = '0;
      exp_last_d = '0;
      model_last_d = 1'b0;
      ack_random = 1'b0;
      stall_cnt = 0;
      stall_addr = '0;
      b_addr_i = '0;
      b_rd_i = 1'b0;
      b_addr = '0;
      b_rd = 1'b0;
      b_wr = 1'b0;
      b_data_out = '0;
      rst_n = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      check("rst_s_rd", s_rd, 1'b0);
      check("rst_s_wr", s_wr, 1'b0);
      check("rst_s_addr", s_addr, 64'd0);
      check("rst_s_wdata", s_wdata, 64'd0);
      check("rst_b_dv", b_dv, 1'b0);
      check("rst_b_dv_i", b_dv_i, 1'b0);
      check("rst_b_data_i", b_data_i, 256'd0);
      check("rst_b_data_in", b_data_in, 256'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // I refill, every beat acked at once; rdata = beat index.
      for (int b = 0; b < 4; b++) begin
         model_mem[64'h1000 + 64'(8 * b)] = 64'(b);
         slave_mem[64'h1000 + 64'(8 * b)] = 64'(b);
      end
      model_round(1'b1, 1'b0, 1'b0, 64'h1010, '0, '0);
      req_i(64'h1010, 0, lat);
      check("lat_i_refill", lat, 5);
      check("i_line_value", b_data_i, {64'd3, 64'd2, 64'd1, 64'd0});
      @(posedge clk);
      #1;

      // D write with a two-cycle stall on beat 1.
      dl = {64'hA3A3_0000_0000_0003, 64'hA2A2_0000_0000_0002,
            64'hA1A1_0000_0000_0001, 64'hA0A0_0000_0000_0000};
      stall_addr = 64'h2008;
      stall_cnt = 2;
      model_round(1'b0, 1'b0, 1'b1, '0, 64'h2000, dl);
      req_d(1'b0, 1'b1, 64'h2000, dl, lat);
      check("lat_d_write_stall", lat, 7);
      @(posedge clk);
      #1;

      // Read and write raised together: write first, then the read of the same line.
      dl = rand_line();
      model_round(1'b0, 1'b1, 1'b1, '0, 64'h3000, dl);
      req_d(1'b1, 1'b1, 64'h3000, dl, lat);
      check("d_rw_readback", b_data_in, dl);
      @(posedge clk);
      #1;

      // Requester holds b_rd_i one cycle past b_dv_i; only one refill may happen.
      model_round(1'b1, 1'b0, 1'b0, 64'h6000, '0, '0);
      req_i(64'h6000, 1, lat);
      repeat (8) @(posedge clk);
      #1;

      // I and D raised together, then all three together.
      model_round(1'b1, 1'b1, 1'b0, 64'h7000, 64'h7100, '0);
      fork
         req_i(64'h7000, 0, lat);
         req_d(1'b1, 1'b0, 64'h7100, '0, lat2);
      join
      check("d_before_i", lat2 < lat, 1'b1);
      @(posedge clk);
      #1;
      dl = rand_line();
      model_round(1'b1, 1'b1, 1'b1, 64'h7200, 64'h7300, dl);
      fork
         req_i(64'h7200, 0, lat);
         req_d(1'b1, 1'b1, 64'h7300, dl, lat2);
      join
      @(posedge clk);
      #1;

      // Reset during beat 2 of a D read.
      stall_addr = 64'h5010;
      stall_cnt = 1000;
      exp_beats.push_back('{wr: 1'b0, addr: 64'h5000, data: model_rd(64'h5000)});
      exp_beats.push_back('{wr: 1'b0, addr: 64'h5008, data: model_rd(64'h5008)});
      b_addr = 64'h5000;
      b_rd = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (s_rd && s_addr == 64'h5010) begin
            found = 1'b1;
            break;
         end
      end
      check("reached_beat2", found, 1'b1);
      rst_n = 1'b0;
      #1;
      check("abort_s_rd", s_rd, 1'b0);
      check("abort_b_dv", b_dv, 1'b0);
      check("abort_s_addr", s_addr, 64'd0);
      check("abort_b_data_in", b_data_in, 256'd0);
      b_rd = 1'b0;
      stall_cnt = 0;
      model_last_d = 1'b0;
      exp_last_i = '0;
      exp_last_d = '0;
      beats_since_done = 0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;
      model_round(1'b0, 1'b1, 1'b0, '0, 64'h5000, '0);
      req_d(1'b1, 1'b0, 64'h5000, '0, lat);
      check("lat_d_after_reset", lat, 5);
      @(posedge clk);
      #1;

      // Randomised rounds with random ack back-pressure.
      ack_random = 1'b1;
      for (int r = 0; r < 40; r++) begin
         k   = $urandom_range(1, 7);
         wi  = k[0];
         wdr = k[1];
         wdw = k[2];
         ia  = 64'h8000 + 64'($urandom_range(0, 7)) * 64'd32 + 64'($urandom_range(0, 31));
         da  = 64'h8000 + 64'($urandom_range(0, 7)) * 64'd32 + 64'($urandom_range(0, 31));
         dl  = rand_line();
         model_round(wi, wdr, wdw, ia, da, dl);
         fork
            begin
               if (wi) req_i(ia, 0, lat);
            end
            begin
               if (wdr || wdw) req_d(wdr, wdw, da, dl, lat2);
            end
         join
         @(posedge clk);
         #1;
      end

      repeat (10) @(posedge clk);
      #1;
      check("beats_drained", exp_beats.size(), 0);
      check("done_drained", exp_done.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
